fetch_pc_gen: RTL and testbench

Fetch-stage PC generator. It sits directly upstream of the branch predictor and drives the two-wide fetch PCs and valids into it. In the same cycle it consumes the predictor's taken/target/GHR outputs to choose the next fetch PC. It also registers a fetch packet toward decode under a valid/ready handshake, and applies redirects from branch resolution with highest priority.

---
 rtl/fetch_pc_gen.sv | 148 ++++++++++++++
 tb/tb_fetch_pc_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Fetch-stage PC generator feeding a two-wide branch predictor lookup. In a
// single cycle it presents pc_q / pc_q+4 to the predictor. It then uses the
// predictor's same-cycle taken/target/GHR response to pick the next fetch PC.
// It also registers a fetch packet toward decode under valid/ready.
// Redirects from branch resolution override everything except reset.
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   o_inst_vld_1/2        predictor lookup valids (slot 1 / slot 2)
//   o_pc_1/2              slot fetch PCs: pc_q, pc_q+4
//   i_brpred_taken        predictor: slot-1 predicted taken
//   i_pc_btb              predictor: predicted target
//   i_ghr                 predictor: GHR snapshot of this lookup
//   i_redirect(_pc)       redirect request and target
//   o_fet_vld / i_dec_rdy packet handshake toward decode
//   o_fet_*               packet payload (base PC, slot-2 valid, prediction)
//   o_redirect_cnt        saturating count of accepted redirects
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int                    PC_WIDTH  = 32,
    parameter int                    GHR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int                    CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 o_inst_vld_1,
    output logic                 o_inst_vld_2,
    output logic [PC_WIDTH-1:0]  o_pc_1,
    output logic [PC_WIDTH-1:0]  o_pc_2,
    input  logic                 i_brpred_taken,
    input  logic [PC_WIDTH-1:0]  i_pc_btb,
    input  logic [GHR_WIDTH-1:0] i_ghr,
    input  logic                 i_redirect,
    input  logic [PC_WIDTH-1:0]  i_redirect_pc,
    output logic                 o_fet_vld,
    input  logic                 i_dec_rdy,
    output logic [PC_WIDTH-1:0]  o_fet_pc,
    output logic                 o_fet_vld_2,
    output logic                 o_fet_pred_taken,
    output logic [PC_WIDTH-1:0]  o_fet_pred_target,
    output logic [GHR_WIDTH-1:0] o_fet_ghr,
    output logic [CNT_WIDTH-1:0] o_redirect_cnt
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    function automatic logic [PC_WIDTH-1:0] align4(input logic [PC_WIDTH-1:0] a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_seq;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  advance;

    logic                  fet_vld_p1;
    logic [PC_WIDTH-1:0]   fet_pc_p1;
    logic                  fet_vld_2_p1;
    logic                  fet_taken_p1;
    logic [PC_WIDTH-1:0]   fet_target_p1;
    logic [GHR_WIDTH-1:0]  fet_ghr_p1;
    logic [CNT_WIDTH-1:0]  redirect_cnt_q;

    // Targets are word-aligned before use; the two LSBs are intentionally dropped.
    logic unused_lsbs;
    assign unused_lsbs = ^{i_pc_btb[1:0], i_redirect_pc[1:0]};

    // Lookup only when the packet register can take the result, so a stalled
    // cycle never triggers a second speculative GHR update in the predictor.
    assign advance = (state_q == ST_RUN) && (!fet_vld_p1 || i_dec_rdy) && !i_redirect;

    assign pc_seq  = pc_q + PC_WIDTH'(8);
    assign pc_next = i_brpred_taken ? align4(i_pc_btb) : pc_seq;

    assign o_inst_vld_1 = advance;
    assign o_inst_vld_2 = advance;
    assign o_pc_1       = pc_q;
    assign o_pc_2       = pc_q + PC_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_redirect) begin
            state_d = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_RST:   state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_RST;
            endcase
        end
    end

    // ---- stage p0 -> p1: fetch PC update and packet register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            fet_vld_p1     <= 1'b0;
            fet_pc_p1      <= '0;
            fet_vld_2_p1   <= 1'b0;
            fet_taken_p1   <= 1'b0;
            fet_target_p1  <= '0;
            fet_ghr_p1     <= '0;
            redirect_cnt_q <= '0;
        end else if (i_redirect) begin
            // Flush even if decode is ready this cycle: the packet is wrong-path.
            pc_q           <= align4(i_redirect_pc);
            fet_vld_p1     <= 1'b0;
            redirect_cnt_q <= sat_inc(redirect_cnt_q);
        end else if (advance) begin
            pc_q          <= pc_next;
            fet_vld_p1    <= 1'b1;
            fet_pc_p1     <= pc_q;
            fet_vld_2_p1  <= !i_brpred_taken;
            fet_taken_p1  <= i_brpred_taken;
            fet_target_p1 <= i_brpred_taken ? i_pc_btb : pc_seq;
            fet_ghr_p1    <= i_ghr;
        end else if (fet_vld_p1 && i_dec_rdy) begin
            fet_vld_p1 <= 1'b0;
        end
    end

    assign o_fet_vld         = fet_vld_p1;
    assign o_fet_pc          = fet_pc_p1;
    assign o_fet_vld_2       = fet_vld_2_p1;
    assign o_fet_pred_taken  = fet_taken_p1;
    assign o_fet_pred_target = fet_target_p1;
    assign o_fet_ghr         = fet_ghr_p1;
    assign o_redirect_cnt    = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

    localparam int PC_WIDTH  = 32;
    localparam int GHR_WIDTH = 10;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 o_inst_vld_1, o_inst_vld_2;
    logic [PC_WIDTH-1:0]  o_pc_1, o_pc_2;
    logic                 i_brpred_taken;
    logic [PC_WIDTH-1:0]  i_pc_btb;
    logic [GHR_WIDTH-1:0] i_ghr;
    logic                 i_redirect;
    logic [PC_WIDTH-1:0]  i_redirect_pc;
    logic                 o_fet_vld;
    logic                 i_dec_rdy;
    logic [PC_WIDTH-1:0]  o_fet_pc;
    logic                 o_fet_vld_2;
    logic                 o_fet_pred_taken;
    logic [PC_WIDTH-1:0]  o_fet_pred_target;
    logic [GHR_WIDTH-1:0] o_fet_ghr;
    logic [CNT_WIDTH-1:0] o_redirect_cnt;

    int n_vec = 0;
    int n_bad = 0;

    fetch_pc_gen #(
        .PC_WIDTH(PC_WIDTH), .GHR_WIDTH(GHR_WIDTH),
        .RESET_PC(32'h0000_0000), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .o_inst_vld_1(o_inst_vld_1), .o_inst_vld_2(o_inst_vld_2),
        .o_pc_1(o_pc_1), .o_pc_2(o_pc_2),
        .i_brpred_taken(i_brpred_taken), .i_pc_btb(i_pc_btb), .i_ghr(i_ghr),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_fet_vld(o_fet_vld), .i_dec_rdy(i_dec_rdy),
        .o_fet_pc(o_fet_pc), .o_fet_vld_2(o_fet_vld_2),
        .o_fet_pred_taken(o_fet_pred_taken), .o_fet_pred_target(o_fet_pred_target),
        .o_fet_ghr(o_fet_ghr), .o_redirect_cnt(o_redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk_pkt(input string tag, input logic [31:0] pc, input logic v2,
                           input logic tk, input logic [31:0] tgt, input logic [9:0] ghr);
        chk({tag, ".vld"},    64'(o_fet_vld),         64'(1'b1));
        chk({tag, ".pc"},     64'(o_fet_pc),          64'(pc));
        chk({tag, ".vld2"},   64'(o_fet_vld_2),       64'(v2));
        chk({tag, ".taken"},  64'(o_fet_pred_taken),  64'(tk));
        chk({tag, ".target"}, 64'(o_fet_pred_target), 64'(tgt));
        chk({tag, ".ghr"},    64'(o_fet_ghr),         64'(ghr));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".fet_vld"}, 64'(o_fet_vld),         64'd0);
        chk({tag, ".fet_pc"},  64'(o_fet_pc),          64'd0);
        chk({tag, ".target"},  64'(o_fet_pred_target), 64'd0);
        chk({tag, ".ghr"},     64'(o_fet_ghr),         64'd0);
        chk({tag, ".taken"},   64'(o_fet_pred_taken),  64'd0);
        chk({tag, ".cnt"},     64'(o_redirect_cnt),    64'd0);
        chk({tag, ".pc1"},     64'(o_pc_1),            64'd0);
        chk({tag, ".ivld"},    64'(o_inst_vld_1),      64'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_dec_rdy = 1'b1; i_brpred_taken = 1'b0; i_pc_btb = '0;
        i_ghr = '0; i_redirect = 1'b0; i_redirect_pc = '0;

        // 1: reset and sequential fetch
        repeat (3) tick();
        chk_reset_state("rst");
        rst_n = 1'b1; settle();
        chk("rst_cycle.ivld1", 64'(o_inst_vld_1), 64'd0);
        tick();
        chk("run0.ivld1", 64'(o_inst_vld_1), 64'd1);
        chk("run0.ivld2", 64'(o_inst_vld_2), 64'd1);
        chk("run0.pc1", 64'(o_pc_1), 64'h0);
        chk("run0.pc2", 64'(o_pc_2), 64'h4);
        tick();
        chk("run1.pc1", 64'(o_pc_1), 64'h8);
        chk_pkt("pkt0", 32'h0, 1'b1, 1'b0, 32'h8, 10'h0);
        tick();
        chk("run2.pc1", 64'(o_pc_1), 64'h10);
        chk_pkt("pkt8", 32'h8, 1'b1, 1'b0, 32'h10, 10'h0);

        // 2: predicted taken
        i_brpred_taken = 1'b1; i_pc_btb = 32'h100; i_ghr = 10'h2A5;
        tick();
        chk_pkt("pkt_taken", 32'h10, 1'b0, 1'b1, 32'h100, 10'h2A5);
        chk("taken.pc1", 64'(o_pc_1), 64'h100);
        // unaligned btb target gets word-aligned into pc_q
        i_pc_btb = 32'h22; i_ghr = 10'h0;
        tick();
        i_brpred_taken = 1'b0; i_pc_btb = '0;
        chk("align.pc1", 64'(o_pc_1), 64'h20);
        chk("align.target", 64'(o_fet_pred_target), 64'h22);
        tick();
        chk_pkt("pkt20", 32'h20, 1'b1, 1'b0, 32'h28, 10'h0);

        // 3: stall
        i_dec_rdy = 1'b0; settle();
        chk("stall.ivld1", 64'(o_inst_vld_1), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall.fet_pc", 64'(o_fet_pc), 64'h20);
            chk("stall.fet_vld", 64'(o_fet_vld), 64'd1);
            chk("stall.pc1", 64'(o_pc_1), 64'h28);
        end
        i_dec_rdy = 1'b1;
        tick();
        chk_pkt("pkt28", 32'h28, 1'b1, 1'b0, 32'h30, 10'h0);

        // 4: redirect beats stall and prediction
        i_redirect = 1'b1; i_redirect_pc = 32'h203; i_dec_rdy = 1'b0;
        i_brpred_taken = 1'b1; i_pc_btb = 32'h500; settle();
        chk("redir.ivld1", 64'(o_inst_vld_1), 64'd0);
        tick();
        i_redirect = 1'b0; i_brpred_taken = 1'b0; i_pc_btb = '0; i_dec_rdy = 1'b1;
        settle();
        chk("redir.fet_vld", 64'(o_fet_vld), 64'd0);
        chk("redir.cnt", 64'(o_redirect_cnt), 64'd1);
        chk("bubble.ivld1", 64'(o_inst_vld_1), 64'd0);
        tick();
        chk("after_bubble.ivld1", 64'(o_inst_vld_1), 64'd1);
        chk("after_bubble.pc1", 64'(o_pc_1), 64'h200);
        tick();
        chk_pkt("pkt200", 32'h200, 1'b1, 1'b0, 32'h208, 10'h0);

        // 5: wrap-around
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        i_redirect = 1'b0;
        tick();
        chk("wrap.pc1", 64'(o_pc_1), 64'hFFFF_FFF8);
        chk("wrap.pc2", 64'(o_pc_2), 64'hFFFF_FFFC);
        tick();
        chk("wrap.next_pc1", 64'(o_pc_1), 64'h0);
        chk_pkt("pkt_wrap", 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0, 10'h0);
        chk("wrap.cnt", 64'(o_redirect_cnt), 64'd2);

        // 6: mid-stream reset with a held packet
        i_ghr = 10'h155; tick();
        i_dec_rdy = 1'b0; i_ghr = 10'h0; tick();
        chk("held.fet_vld", 64'(o_fet_vld), 64'd1);
        chk("held.ghr", 64'(o_fet_ghr), 64'h155);
        rst_n = 1'b0; tick();
        chk_reset_state("midrst");
        rst_n = 1'b1; i_dec_rdy = 1'b1;

        // Back-to-back redirects starting in RST up to saturation
        i_redirect = 1'b1;
        for (int i = 0; i < 32'hFFFF; i++) begin
            i_redirect_pc = (i == 32'hFFFE) ? 32'h1234 : 32'(i * 4);
            tick();
            if (i == 32'hFFFD) chk("cnt.almost", 64'(o_redirect_cnt), 64'hFFFE);
        end
        chk("cnt.sat", 64'(o_redirect_cnt), 64'hFFFF);
        chk("b2b.pc1", 64'(o_pc_1), 64'h1234);
        chk("b2b.fet_vld", 64'(o_fet_vld), 64'd0);
        i_redirect_pc = 32'h40; tick();
        chk("cnt.hold", 64'(o_redirect_cnt), 64'hFFFF);
        i_redirect = 1'b0; settle();
        chk("flush_restart.ivld1", 64'(o_inst_vld_1), 64'd0);
        tick();
        chk("final.pc1", 64'(o_pc_1), 64'h40);
        chk("final.ivld1", 64'(o_inst_vld_1), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
